// File: rtl/instr_fetch.sv
// Program counter and instruction-fetch sequencer feeding the decoder.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic            halt,
  input  logic            branch_inst,
  input  logic            branch_taken,
  input  logic            jump_en,
  input  logic [8:0]      jump_addr,
  input  logic [8:0]      insn_rdata,
  output logic [PC_W-1:0] pc,
  output logic [8:0]      instruction,
  output logic            read_jump,
  output logic            insn_valid,
  output logic            done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     cycle_count,
  output logic [15:0]     insn_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_JUMP,
    S_HALTED
  } state_e;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            start_accept;

  // Only IDLE and HALTED honour start; RUN and JUMP ignore it.
  assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_HALTED));

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (branch_inst && branch_taken) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_JUMP;
        end else if (branch_inst) begin
          pc_d    = pc_q + PC_W'(2);
        end else begin
          pc_d    = pc_q + PC_W'(1);
        end
      end
      S_JUMP: begin
        // A missing jump_en is tolerated by stepping past the target word.
        pc_d    = jump_en ? PC_W'(jump_addr) : pc_q + PC_W'(1);
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc          = pc_q;
  assign instruction = insn_rdata;
  assign read_jump   = (state_q == S_JUMP);
  assign insn_valid  = (state_q == S_RUN) || (state_q == S_JUMP);
  assign done        = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cycle_count_q, cycle_count_d;
  logic [15:0] insn_count_q, insn_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    insn_count_d  = insn_count_q;
    if (start_accept) begin
      cycle_count_d = '0;
      insn_count_d  = '0;
    end else begin
      if (insn_valid && (cycle_count_q != 16'hFFFF)) cycle_count_d = cycle_count_q + 16'd1;
      if ((state_q == S_RUN) && (insn_count_q != 16'hFFFF)) insn_count_d = insn_count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycle_count_q <= '0;
      insn_count_q  <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      insn_count_q  <= insn_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign insn_count  = insn_count_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// stimulus compared against a rule-level reference model.
module tb_instr_fetch;

  localparam int PC_W = 10;
  localparam int PC_MOD = 1 << PC_W;

  logic            Clk;
  logic            Reset;
  logic            start, halt, branch_inst, branch_taken, jump_en;
  logic [8:0]      jump_addr;
  logic [8:0]      insn_rdata;
  logic [PC_W-1:0] pc;
  logic [8:0]      instruction;
  logic            read_jump, insn_valid, done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]     cycle_count, insn_count;
`endif

  logic [8:0] rom [PC_MOD];

  int checks;
  int failures;

  instr_fetch #(.PC_W(PC_W), .START_ADDR(0)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .halt         (halt),
    .branch_inst  (branch_inst),
    .branch_taken (branch_taken),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .insn_rdata   (insn_rdata),
    .pc           (pc),
    .instruction  (instruction),
    .read_jump    (read_jump),
    .insn_valid   (insn_valid),
    .done         (done)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cycle_count  (cycle_count),
    .insn_count   (insn_count)
`endif
  );

  assign insn_rdata = rom[pc];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: processor mode, pc as an integer, and plain counters.
  typedef enum {M_IDLE, M_RUN, M_TARGET, M_HALTED} mode_t;
  mode_t m_mode;
  int    m_pc;
  int    m_cyc;
  int    m_ins;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_cyc  = 0;
    m_ins  = 0;
  endtask

  task automatic model_step();
    mode_t cur;
    cur = m_mode;
    if (cur == M_RUN || cur == M_TARGET) m_cyc = (m_cyc < 65535) ? m_cyc + 1 : m_cyc;
    if (cur == M_RUN) m_ins = (m_ins < 65535) ? m_ins + 1 : m_ins;
    if (cur == M_IDLE || cur == M_HALTED) begin
      if (start) begin
        m_pc = 0; m_mode = M_RUN; m_cyc = 0; m_ins = 0;
      end
    end else if (cur == M_RUN) begin
      if (halt) m_mode = M_HALTED;
      else if (branch_inst && branch_taken) begin
        m_pc = (m_pc + 1) % PC_MOD; m_mode = M_TARGET;
      end else if (branch_inst) m_pc = (m_pc + 2) % PC_MOD;
      else m_pc = (m_pc + 1) % PC_MOD;
    end else begin
      m_pc   = jump_en ? int'(jump_addr) : (m_pc + 1) % PC_MOD;
      m_mode = M_RUN;
    end
  endtask

  task automatic clear_inputs();
    start = 0; halt = 0; branch_inst = 0; branch_taken = 0;
    jump_en = 0; jump_addr = '0;
  endtask

  // Advance one clock; inputs are sampled at the edge, outputs read 1 unit later.
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1;
    model_reset();
    #3;
    Reset = 0;
  endtask

  // From RUN, take a branch and land on addr.
  task automatic goto_addr(input logic [8:0] addr);
    clear_inputs();
    branch_inst = 1; branch_taken = 1;
    tick();
    clear_inputs();
    jump_en = 1; jump_addr = addr;
    tick();
    clear_inputs();
  endtask

  task automatic start_run();
    clear_inputs();
    start = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1;
    model_reset();
    #1;
    checks++;
    if (pc !== 10'h000 || insn_valid !== 1'b0 || done !== 1'b0 || read_jump !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pc=%h iv=%b done=%b rj=%b required pc=000 iv=0 done=0 rj=0",
               pc, insn_valid, done, read_jump);
    end
    #3;
    Reset = 0;
    tick();
    checks++;
    if (pc !== 10'h000 || insn_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: pc=%h iv=%b required pc=000 iv=0", pc, insn_valid);
    end
  endtask

  task automatic test_async_reset();
    start_run();
    goto_addr(9'h025);
    checks++;
    if (pc !== 10'h025 || insn_valid !== 1'b1) begin
      failures++;
      $display("FAIL reach_025: pc=%h iv=%b required pc=025 iv=1", pc, insn_valid);
    end
    #2;
    Reset = 1;
    model_reset();
    #1;
    checks++;
    if (pc !== 10'h000 || insn_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: pc=%h iv=%b done=%b required pc=000 iv=0 done=0",
               pc, insn_valid, done);
    end
    Reset = 0;
    #1;
  endtask

  task automatic test_sequential();
    start_run();
    checks++;
    if (pc !== 10'h000 || insn_valid !== 1'b1 || read_jump !== 1'b0) begin
      failures++;
      $display("FAIL seq_first: pc=%h iv=%b rj=%b required pc=000 iv=1 rj=0",
               pc, insn_valid, read_jump);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (pc !== PC_W'(i) || instruction !== rom[i]) begin
        failures++;
        $display("FAIL seq_pc%0d: pc=%h instr=%h required pc=%h instr=%h",
                 i, pc, instruction, i[PC_W-1:0], rom[i]);
      end
    end
  endtask

  task automatic test_branch_taken();
    goto_addr(9'h010);
    branch_inst = 1; branch_taken = 1; jump_en = 1; jump_addr = 9'h055;
    tick();
    branch_inst = 0; branch_taken = 0;
    checks++;
    if (pc !== 10'h011 || read_jump !== 1'b1 || insn_valid !== 1'b1) begin
      failures++;
      $display("FAIL taken_target: pc=%h rj=%b iv=%b required pc=011 rj=1 iv=1",
               pc, read_jump, insn_valid);
    end
    tick();
    clear_inputs();
    checks++;
    if (pc !== 10'h055 || read_jump !== 1'b0) begin
      failures++;
      $display("FAIL taken_jump: pc=%h rj=%b required pc=055 rj=0", pc, read_jump);
    end
  endtask

  task automatic test_branch_not_taken();
    goto_addr(9'h010);
    branch_inst = 1;
    tick();
    clear_inputs();
    checks++;
    if (pc !== 10'h012 || read_jump !== 1'b0) begin
      failures++;
      $display("FAIL not_taken: pc=%h rj=%b required pc=012 rj=0", pc, read_jump);
    end
    goto_addr(9'h1FF);
    repeat (10'h200) tick();
    checks++;
    if (pc !== 10'h3FF) begin
      failures++;
      $display("FAIL reach_3ff: pc=%h required 3ff", pc);
    end
    branch_inst = 1;
    tick();
    clear_inputs();
    checks++;
    if (pc !== 10'h001) begin
      failures++;
      $display("FAIL wrap_plus2: pc=%h required 001", pc);
    end
    goto_addr(9'h1FF);
    repeat (10'h200) tick();
    tick();
    checks++;
    if (pc !== 10'h000) begin
      failures++;
      $display("FAIL wrap_plus1: pc=%h required 000", pc);
    end
  endtask

  task automatic test_halt_priority();
    goto_addr(9'h020);
    halt = 1; branch_inst = 1; branch_taken = 1;
    tick();
    clear_inputs();
    checks++;
    if (pc !== 10'h020 || done !== 1'b1 || insn_valid !== 1'b0 || read_jump !== 1'b0) begin
      failures++;
      $display("FAIL halt_wins: pc=%h done=%b iv=%b rj=%b required pc=020 done=1 iv=0 rj=0",
               pc, done, insn_valid, read_jump);
    end
    tick();
    checks++;
    if (pc !== 10'h020 || done !== 1'b1) begin
      failures++;
      $display("FAIL halt_hold: pc=%h done=%b required pc=020 done=1", pc, done);
    end
    start_run();
    checks++;
    if (pc !== 10'h000 || done !== 1'b0 || insn_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart: pc=%h done=%b iv=%b required pc=000 done=0 iv=1",
               pc, done, insn_valid);
    end
  endtask

  task automatic test_jump_en_low();
    goto_addr(9'h030);
    branch_inst = 1; branch_taken = 1;
    tick();
    clear_inputs();
    halt = 1; start = 1; branch_inst = 1; branch_taken = 1; jump_addr = 9'h0AA;
    tick();
    clear_inputs();
    checks++;
    if (pc !== 10'h032 || read_jump !== 1'b0 || insn_valid !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL jump_en_low: pc=%h rj=%b iv=%b done=%b required pc=032 rj=0 iv=1 done=0",
               pc, read_jump, insn_valid, done);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    clear_inputs();
    start_run();
    repeat (3) tick();
    branch_inst = 1; branch_taken = 1;
    tick();
    clear_inputs();
    jump_en = 1; jump_addr = 9'h040;
    tick();
    clear_inputs();
    halt = 1;
    tick();
    clear_inputs();
    checks++;
    if (done !== 1'b1 || cycle_count !== 16'd6 || insn_count !== 16'd5) begin
      failures++;
      $display("FAIL perf_counts: done=%b cyc=%0d ins=%0d required done=1 cyc=6 ins=5",
               done, cycle_count, insn_count);
    end
    tick();
    checks++;
    if (cycle_count !== 16'd6 || insn_count !== 16'd5) begin
      failures++;
      $display("FAIL perf_hold: cyc=%0d ins=%0d required cyc=6 ins=5", cycle_count, insn_count);
    end
    start_run();
    checks++;
    if (cycle_count !== 16'd0 || insn_count !== 16'd0) begin
      failures++;
      $display("FAIL perf_clear: cyc=%0d ins=%0d required 0 0", cycle_count, insn_count);
    end
  endtask
`endif

  task automatic test_random();
    int bad;
    apply_reset();
    clear_inputs();
    for (int i = 0; i < 600; i++) begin
      start        = ($urandom % 16) == 0;
      halt         = ($urandom % 24) == 0;
      branch_inst  = ($urandom % 4) == 0;
      branch_taken = $urandom % 2;
      jump_en      = ($urandom % 8) != 0;
      jump_addr    = 9'($urandom);
      tick();
      bad = 0;
      if (pc !== PC_W'(m_pc)) bad = 1;
      if (read_jump !== (m_mode == M_TARGET)) bad = 1;
      if (insn_valid !== (m_mode == M_RUN || m_mode == M_TARGET)) bad = 1;
      if (done !== (m_mode == M_HALTED)) bad = 1;
      if (instruction !== rom[m_pc]) bad = 1;
`ifdef FETCH_PERF_CNT_EN
      if (cycle_count !== 16'(m_cyc) || insn_count !== 16'(m_ins)) bad = 1;
`endif
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL random_cycle%0d: pc=%h rj=%b iv=%b done=%b required pc=%h mode=%s",
                 i, pc, read_jump, insn_valid, done, m_pc[PC_W-1:0], m_mode.name());
      end
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int a = 0; a < PC_MOD; a++) rom[a] = 9'($urandom);
    test_reset();
    test_async_reset();
    test_sequential();
    test_branch_taken();
    test_branch_not_taken();
    test_halt_priority();
    test_jump_en_low();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
